// File: rtl/VX_om_pkg.sv
// VX_om_pkg: shared types and defaults for the output-merger pixel lock.
//   OM_DIM_BITS     - pixel coordinate width (from `VX_OM_DIM_BITS)
//   OM_NUM_LANES    - default lanes per request
//   OM_LOCK_SIZE    - default number of lock slots
//   om_lock_entry_t - one lock slot at the default lane count
`ifndef VX_OM_DIM_BITS
`define VX_OM_DIM_BITS 8
`endif

package VX_om_pkg;

   localparam int OM_DIM_BITS  = `VX_OM_DIM_BITS;
   localparam int OM_NUM_LANES = 4;
   localparam int OM_LOCK_SIZE = 8;

   typedef struct packed {
      logic                                     valid;
      logic [OM_NUM_LANES-1:0]                  mask;
      logic [OM_NUM_LANES-1:0][OM_DIM_BITS-1:0] pos_x;
      logic [OM_NUM_LANES-1:0][OM_DIM_BITS-1:0] pos_y;
   } om_lock_entry_t;

endpackage

// File: rtl/om_pixel_lock_match.sv
// om_lock_match: combinational comparison of one request against every lock slot.
//   req_mask/req_pos_x/req_pos_y    - incoming request lanes
//   slot_valid/slot_mask/slot_pos_* - registered lock table
//   bypass                          - slots being released this cycle (ignored)
//   conflict                        - per-slot hit vector
module om_lock_match #(
   parameter int NUM_LANES = 4,
   parameter int LOCK_SIZE = 8,
   parameter int DIM_BITS  = 8
) (
   input  logic [NUM_LANES-1:0]                               req_mask,
   input  logic [NUM_LANES-1:0][DIM_BITS-1:0]                 req_pos_x,
   input  logic [NUM_LANES-1:0][DIM_BITS-1:0]                 req_pos_y,
   input  logic [LOCK_SIZE-1:0]                               slot_valid,
   input  logic [LOCK_SIZE-1:0][NUM_LANES-1:0]                slot_mask,
   input  logic [LOCK_SIZE-1:0][NUM_LANES-1:0][DIM_BITS-1:0]  slot_pos_x,
   input  logic [LOCK_SIZE-1:0][NUM_LANES-1:0][DIM_BITS-1:0]  slot_pos_y,
   input  logic [LOCK_SIZE-1:0]                               bypass,
   output logic [LOCK_SIZE-1:0]                               conflict
);

   always_comb begin
      conflict = '0;
      for (int unsigned s = 0; s < LOCK_SIZE; s++) begin
         for (int unsigned i = 0; i < NUM_LANES; i++) begin
            for (int unsigned j = 0; j < NUM_LANES; j++) begin
               if (slot_valid[s] && !bypass[s] && req_mask[i] && slot_mask[s][j]
                   && (req_pos_x[i] == slot_pos_x[s][j])
                   && (req_pos_y[i] == slot_pos_y[s][j])) begin
                  conflict[s] = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/om_pixel_lock.sv
// om_pixel_lock: per-pixel read-modify-write lock in front of the OM memory stage.
// A read (in_rw=0) allocates the lowest free slot and records its lanes; a
// request overlapping any held slot stalls until that slot is released.
//   in_*      - request (valid/rw/mask/pos_x/pos_y/tag), in_ready handshake
//   out_*     - registered request plus allocated slot, out_ready handshake
//   rel_*     - slot release strobe from the blend stage (always accepted)
//   lock_count/lock_full - slot occupancy
// Optional macro VX_OM_LOCK_PERF_EN adds perf_stall_cycles / perf_alloc_count.
module om_pixel_lock
   import VX_om_pkg::*;
#(
   parameter int NUM_LANES = OM_NUM_LANES,
   parameter int LOCK_SIZE = OM_LOCK_SIZE,
   parameter int LOCK_BITS = $clog2(LOCK_SIZE),
   parameter int TAG_WIDTH = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 in_valid,
   input  logic                                 in_rw,
   input  logic [NUM_LANES-1:0]                 in_mask,
   input  logic [NUM_LANES-1:0][OM_DIM_BITS-1:0] in_pos_x,
   input  logic [NUM_LANES-1:0][OM_DIM_BITS-1:0] in_pos_y,
   input  logic [TAG_WIDTH-1:0]                 in_tag,
   output logic                                 in_ready,
   output logic                                 out_valid,
   output logic                                 out_rw,
   output logic [NUM_LANES-1:0]                 out_mask,
   output logic [NUM_LANES-1:0][OM_DIM_BITS-1:0] out_pos_x,
   output logic [NUM_LANES-1:0][OM_DIM_BITS-1:0] out_pos_y,
   output logic [TAG_WIDTH-1:0]                 out_tag,
   output logic [LOCK_BITS-1:0]                 out_slot,
   input  logic                                 out_ready,
   input  logic                                 rel_valid,
   input  logic [LOCK_BITS-1:0]                 rel_slot,
   output logic [LOCK_BITS:0]                   lock_count,
   output logic                                 lock_full
`ifdef VX_OM_LOCK_PERF_EN
   ,
   output logic [31:0]                          perf_stall_cycles,
   output logic [31:0]                          perf_alloc_count
`endif
);

   localparam int DIM_BITS = OM_DIM_BITS;
   localparam int CNT_BITS = LOCK_BITS + 1;

   logic [LOCK_SIZE-1:0]                              slot_valid;
   logic [LOCK_SIZE-1:0][NUM_LANES-1:0]               slot_mask;
   logic [LOCK_SIZE-1:0][NUM_LANES-1:0][DIM_BITS-1:0] slot_pos_x;
   logic [LOCK_SIZE-1:0][NUM_LANES-1:0][DIM_BITS-1:0] slot_pos_y;

   logic [LOCK_SIZE-1:0] rel_mask;
   logic [LOCK_SIZE-1:0] conflict;
   logic                 free_found;
   logic [LOCK_BITS-1:0] free_idx;
   logic                 pipe_free;
   logic                 accept;
   logic                 alloc;
   logic                 rel_fire;

   always_comb begin
      rel_mask = '0;
      if (rel_valid) rel_mask[rel_slot] = 1'b1;
   end

   om_lock_match #(
      .NUM_LANES (NUM_LANES),
      .LOCK_SIZE (LOCK_SIZE),
      .DIM_BITS  (DIM_BITS)
   ) u_match (
      .req_mask   (in_mask),
      .req_pos_x  (in_pos_x),
      .req_pos_y  (in_pos_y),
      .slot_valid (slot_valid),
      .slot_mask  (slot_mask),
      .slot_pos_x (slot_pos_x),
      .slot_pos_y (slot_pos_y),
      .bypass     (rel_mask),
      .conflict   (conflict)
   );

   // Free search uses the registered table only, so a slot released this
   // cycle is never handed out in the same cycle.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int unsigned s = 0; s < LOCK_SIZE; s++) begin
         if (!slot_valid[s] && !free_found) begin
            free_found = 1'b1;
            free_idx   = LOCK_BITS'(s);
         end
      end
   end

   assign pipe_free = !out_valid || out_ready;
   assign in_ready  = pipe_free && !(|conflict) && (in_rw || free_found);
   assign accept    = in_valid && in_ready;
   assign alloc     = accept && !in_rw;
   assign rel_fire  = rel_valid && slot_valid[rel_slot];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_valid <= '0;
         slot_mask  <= '0;
         slot_pos_x <= '0;
         slot_pos_y <= '0;
      end else begin
         if (rel_valid) slot_valid[rel_slot] <= 1'b0;
         if (alloc) begin
            slot_valid[free_idx] <= 1'b1;
            slot_mask[free_idx]  <= in_mask;
            slot_pos_x[free_idx] <= in_pos_x;
            slot_pos_y[free_idx] <= in_pos_y;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_count <= '0;
      end else if (alloc && !rel_fire) begin
         lock_count <= lock_count + CNT_BITS'(1);
      end else if (!alloc && rel_fire) begin
         lock_count <= lock_count - CNT_BITS'(1);
      end
   end

   assign lock_full = (lock_count == CNT_BITS'(LOCK_SIZE));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_rw    <= 1'b0;
         out_mask  <= '0;
         out_pos_x <= '0;
         out_pos_y <= '0;
         out_tag   <= '0;
         out_slot  <= '0;
      end else if (pipe_free) begin
         out_valid <= accept;
         if (accept) begin
            out_rw    <= in_rw;
            out_mask  <= in_mask;
            out_pos_x <= in_pos_x;
            out_pos_y <= in_pos_y;
            out_tag   <= in_tag;
            out_slot  <= in_rw ? '0 : free_idx;
         end
      end
   end

`ifdef VX_OM_LOCK_PERF_EN
   // Stalls are counted only while the output stage could take the request,
   // so downstream backpressure does not contribute.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cycles <= '0;
         perf_alloc_count  <= '0;
      end else begin
         if (in_valid && !in_ready && pipe_free) perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (alloc) perf_alloc_count <= perf_alloc_count + 32'd1;
      end
   end
`endif

   rel_of_free_slot : assert property (@(posedge clk) disable iff (reset)
      rel_valid |-> slot_valid[rel_slot]);

endmodule

// File: tb/tb_om_pixel_lock.sv
`ifndef VX_OM_DIM_BITS
`define VX_OM_DIM_BITS 8
`endif

module tb_om_pixel_lock;

   localparam int NL = 4;
   localparam int LS = 8;
   localparam int LB = 3;
   localparam int DB = `VX_OM_DIM_BITS;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  in_valid = 1'b0;
   logic                  in_rw = 1'b0;
   logic [NL-1:0]         in_mask = '0;
   logic [NL-1:0][DB-1:0] in_pos_x = '0;
   logic [NL-1:0][DB-1:0] in_pos_y = '0;
   logic [0:0]            in_tag = '0;
   logic                  in_ready;
   logic                  out_valid;
   logic                  out_rw;
   logic [NL-1:0]         out_mask;
   logic [NL-1:0][DB-1:0] out_pos_x;
   logic [NL-1:0][DB-1:0] out_pos_y;
   logic [0:0]            out_tag;
   logic [LB-1:0]         out_slot;
   logic                  out_ready = 1'b1;
   logic                  rel_valid = 1'b0;
   logic [LB-1:0]         rel_slot = '0;
   logic [LB:0]           lock_count;
   logic                  lock_full;
`ifdef VX_OM_LOCK_PERF_EN
   logic [31:0]           perf_stall_cycles;
   logic [31:0]           perf_alloc_count;
`endif

   om_pixel_lock #(
      .NUM_LANES (NL),
      .LOCK_SIZE (LS),
      .TAG_WIDTH (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_rw      (in_rw),
      .in_mask    (in_mask),
      .in_pos_x   (in_pos_x),
      .in_pos_y   (in_pos_y),
      .in_tag     (in_tag),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_rw     (out_rw),
      .out_mask   (out_mask),
      .out_pos_x  (out_pos_x),
      .out_pos_y  (out_pos_y),
      .out_tag    (out_tag),
      .out_slot   (out_slot),
      .out_ready  (out_ready),
      .rel_valid  (rel_valid),
      .rel_slot   (rel_slot),
      .lock_count (lock_count),
      .lock_full  (lock_full)
`ifdef VX_OM_LOCK_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_alloc_count  (perf_alloc_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the lock table as plain arrays, the output stage as a
   // set of expected fields.
   logic          m_valid [LS];
   logic [NL-1:0] m_mask  [LS];
   int            m_x     [LS][NL];
   int            m_y     [LS][NL];
   logic          e_ov;
   logic          e_rw;
   logic [NL-1:0] e_mask;
   logic [NL-1:0][DB-1:0] e_x;
   logic [NL-1:0][DB-1:0] e_y;
   logic [0:0]    e_tag;
   int            e_slot;

   always @(negedge clk) begin
      int  cnt;
      int  free_s;
      bit  hit;
      bit  rdy;
      if (reset) begin
         for (int s = 0; s < LS; s++) m_valid[s] = 1'b0;
         e_ov = 1'b0;
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_lock_count", 64'(lock_count), 64'd0);
         chk("rst_lock_full", 64'(lock_full), 64'd0);
         chk("rst_out_slot", 64'(out_slot), 64'd0);
      end else begin
         cnt = 0;
         for (int s = 0; s < LS; s++) if (m_valid[s]) cnt++;
         chk("lock_count", 64'(lock_count), 64'(cnt));
         chk("lock_full", 64'(lock_full), 64'(cnt == LS));
         chk("out_valid", 64'(out_valid), 64'(e_ov));
         if (e_ov) begin
            chk("out_rw", 64'(out_rw), 64'(e_rw));
            chk("out_mask", 64'(out_mask), 64'(e_mask));
            chk("out_pos_x", 64'(out_pos_x), 64'(e_x));
            chk("out_pos_y", 64'(out_pos_y), 64'(e_y));
            chk("out_tag", 64'(out_tag), 64'(e_tag));
            chk("out_slot", 64'(out_slot), 64'(e_slot));
         end
         hit = 1'b0;
         for (int s = 0; s < LS; s++) begin
            if (m_valid[s] && !(rel_valid && int'(rel_slot) == s)) begin
               for (int i = 0; i < NL; i++)
                  for (int j = 0; j < NL; j++)
                     if (in_mask[i] && m_mask[s][j] && int'(in_pos_x[i]) == m_x[s][j]
                         && int'(in_pos_y[i]) == m_y[s][j]) hit = 1'b1;
            end
         end
         free_s = -1;
         for (int s = LS - 1; s >= 0; s--) if (!m_valid[s]) free_s = s;
         rdy = (!e_ov || out_ready) && !hit && (in_rw || free_s >= 0);
         chk("in_ready", 64'(in_ready), 64'(rdy));
         if (rel_valid) m_valid[rel_slot] = 1'b0;
         if (!e_ov || out_ready) begin
            e_ov = in_valid && rdy;
            if (in_valid && rdy) begin
               e_rw = in_rw; e_mask = in_mask; e_x = in_pos_x; e_y = in_pos_y; e_tag = in_tag;
               e_slot = in_rw ? 0 : free_s;
               if (!in_rw) begin
                  m_valid[free_s] = 1'b1;
                  m_mask[free_s]  = in_mask;
                  for (int i = 0; i < NL; i++) begin
                     m_x[free_s][i] = int'(in_pos_x[i]);
                     m_y[free_s][i] = int'(in_pos_y[i]);
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; rel_valid = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   // Request with lane0 at (x,y) and the other lanes parked far away.
   task automatic req1(input logic rw, input logic [NL-1:0] m, input int x, input int y);
      in_valid = 1'b1; in_rw = rw; in_mask = m; in_tag = 1'b0;
      for (int i = 0; i < NL; i++) begin
         in_pos_x[i] = DB'(x);
         in_pos_y[i] = DB'(y + 100 + i);
      end
      in_pos_y[0] = DB'(y);
   endtask

   initial begin
      int base, step, p, s;

      do_reset();
      out_ready = 1'b1;
      chk("t0_lock_count", 64'(lock_count), 64'd0);
      chk("t0_out_valid", 64'(out_valid), 64'd0);

      // Read at (1,1),(2,1),(3,1),(4,1), then a read touching (3,1).
      in_valid = 1'b1; in_rw = 1'b0; in_mask = 4'b1111; in_tag = 1'b1;
      for (int i = 0; i < NL; i++) begin in_pos_x[i] = DB'(i + 1); in_pos_y[i] = DB'(1); end
      #1 chk("t1_ready", 64'(in_ready), 64'd1);
      tick();
      chk("t1_slot", 64'(out_slot), 64'd0);
      chk("t1_count", 64'(lock_count), 64'd1);
      for (int i = 0; i < NL; i++) begin in_pos_x[i] = DB'(i + 7); in_pos_y[i] = DB'(7); end
      in_pos_x[0] = DB'(3); in_pos_y[0] = DB'(1);
      #1 chk("t1_stall", 64'(in_ready), 64'd0);
      tick();
      chk("t1_stall2", 64'(in_ready), 64'd0);
      rel_valid = 1'b1; rel_slot = 3'd0;
      #1 chk("t1_rel_bypass", 64'(in_ready), 64'd1);
      tick();
      rel_valid = 1'b0; in_valid = 1'b0;
      chk("t1_slot_b", 64'(out_slot), 64'd1);
      chk("t1_count_b", 64'(lock_count), 64'd1);

      // Fill all eight slots, then a ninth read and a blind write.
      do_reset();
      for (int k = 0; k < LS; k++) begin
         req1(1'b0, 4'b0001, 10 + k, 10);
         tick();
      end
      chk("t2_slot7", 64'(out_slot), 64'd7);
      chk("t2_count", 64'(lock_count), 64'd8);
      chk("t2_full", 64'(lock_full), 64'd1);
      req1(1'b0, 4'b0001, 20, 20);
      #1 chk("t2_ninth_stall", 64'(in_ready), 64'd0);
      req1(1'b1, 4'b0001, 30, 30);
      #1 chk("t2_write_ready", 64'(in_ready), 64'd1);
      tick();
      chk("t2_write_slot", 64'(out_slot), 64'd0);
      chk("t2_write_rw", 64'(out_rw), 64'd1);

      // Release slot 3 alongside a new read: read waits a cycle then takes slot 3.
      req1(1'b0, 4'b0001, 40, 40);
      rel_valid = 1'b1; rel_slot = 3'd3;
      #1 chk("t3_wait", 64'(in_ready), 64'd0);
      tick();
      rel_valid = 1'b0;
      #1 chk("t3_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("t3_slot", 64'(out_slot), 64'd3);
      chk("t3_count", 64'(lock_count), 64'd8);

      // Inactive lanes never conflict.
      do_reset();
      req1(1'b0, 4'b0001, 5, 5);
      tick();
      req1(1'b0, 4'b0010, 5, 5);
      in_pos_x[1] = DB'(5); in_pos_y[1] = DB'(5);
      #1 chk("t4_stall", 64'(in_ready), 64'd0);
      in_pos_x[1] = DB'(6); in_pos_y[1] = DB'(6);
      #1 chk("t4_pass", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("t4_slot", 64'(out_slot), 64'd1);
      tick();

      // Backpressure holds the output, then reset mid-stall.
      out_ready = 1'b0;
      req1(1'b0, 4'b0001, 50, 50);
      tick();
      req1(1'b0, 4'b0001, 60, 60);
      for (int k = 0; k < 3; k++) begin
         #1 chk("t5_ready", 64'(in_ready), 64'd0);
         chk("t5_hold_valid", 64'(out_valid), 64'd1);
         chk("t5_hold_x", 64'(out_pos_x[0]), 64'd50);
         tick();
      end
      reset = 1'b1;
      #1 chk("t5_rst_valid", 64'(out_valid), 64'd0);
      chk("t5_rst_count", 64'(lock_count), 64'd0);
      in_valid = 1'b0;
      tick();
      reset = 1'b0; out_ready = 1'b1;
      req1(1'b0, 4'b0001, 70, 70);
      tick();
      in_valid = 1'b0;
      chk("t5_slot0", 64'(out_slot), 64'd0);
      chk("t5_count", 64'(lock_count), 64'd1);

      // Randomised traffic over a tiny 4x2 pixel window to force overlap.
      for (int c = 0; c < 3000; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_rw = ($urandom_range(0, 4) == 0);
         in_mask = NL'($urandom_range(0, 15));
         in_tag = 1'($urandom);
         base = int'($urandom_range(0, 7));
         step = 2 * int'($urandom_range(0, 3)) + 1;
         for (int i = 0; i < NL; i++) begin
            p = (base + i * step) % 8;
            in_pos_x[i] = DB'(p % 4);
            in_pos_y[i] = DB'(p / 4);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         rel_valid = 1'b0;
         if ($urandom_range(0, 2) == 0) begin
            s = int'($urandom_range(0, LS - 1));
            if (m_valid[s]) begin
               rel_valid = 1'b1;
               rel_slot = LB'(s);
            end
         end
         tick();
      end
      in_valid = 1'b0; rel_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/om_pixel_lock.md
# om_pixel_lock

Per-pixel read-modify-write lock for the output-merger (OM) path. It sits directly upstream of the OM memory stage and holds back a fragment request whose pixel position overlaps a read-modify-write that is still in flight. Each accepted read allocates one lock slot that records the request's (x,y) lanes; the downstream blend stage frees the slot once its write-back has been accepted by the memory stage. This prevents depth/stencil/blend read-after-write hazards on the same pixel.

## Interface
- NUM_LANES, 4, lanes per request
- LOCK_SIZE, 8, number of lock slots (power of two, ≥2)
- LOCK_BITS, `CLOG2(LOCK_SIZE), slot index width (derived)
- TAG_WIDTH, 1, opaque request tag, passed through unchanged

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- in_valid  in  1  request valid
- in_rw  in  1  0 = RMW read (allocates a slot), 1 = blind write (no allocation)
- in_mask  in  NUM_LANES  active lanes
- in_pos_x / in_pos_y  in  NUM_LANES×`VX_OM_DIM_BITS`  pixel positions
- in_tag  in  TAG_WIDTH  tag
- in_ready  out  1  request accepted when in_valid && in_ready
- out_valid, out_rw, out_mask, out_pos_x, out_pos_y, out_tag  out  as in_*  registered request
- out_slot  out  LOCK_BITS  allocated slot; 0 when out_rw=1
- out_ready  in  1  downstream ready
- rel_valid  in  1  release strobe; always accepted
- rel_slot  in  LOCK_BITS  slot to free
- lock_count  out  LOCK_BITS+1  number of occupied slots
- lock_full  out  1  lock_count == LOCK_SIZE

## Operation
- Each slot holds: valid, a lane mask, and per-lane (x,y).
- Conflict: any active input lane whose (x,y) equals an active lane of a valid slot. Slots being released this cycle (rel_valid && rel_slot == s) are excluded from the check.
- Within a single request, lanes are guaranteed distinct and are not checked against one another.
- Accept condition: (~out_valid || out_ready) && ~conflict && (in_rw || free slot exists).
- A read is accepted even when in_mask == 0; it still allocates a slot.
- Free-slot selection: lowest-index slot with valid=0 in the registered table. A slot freed in the same cycle is not reused that cycle.
- On an accepted read, the chosen slot's valid bit, mask and positions are written, and its index goes to out_slot.
- Release sets valid=0 on the next edge. Releasing an already-free slot is a no-op and trips a simulation assertion.
- lock_count is updated as +1 (alloc) −1 (release); a simultaneous alloc and release leaves it unchanged.
- All data is passed through unmodified.

## Timing
- Output stage is a single pipe register; latency is 1 cycle from acceptance to out_valid.
- in_ready is combinational from in_*, rel_* and out_ready. It does not depend on in_valid.
- An allocation is visible to the conflict check from the next cycle. Back-to-back requests to the same pixel therefore stall the second request until the slot is released.
- Same-cycle release and conflicting request: the request is accepted in that cycle.
- Full table: reads stall until a release; blind writes still flow if they have no conflict.
- Reset (at any time, including mid-operation):
  - all slots go invalid;
  - out_valid = 0, lock_count = 0, lock_full = 0, out_slot = 0;
  - in-flight locks are lost, and downstream is reset together with this block.

## Configuration
- VX_OM_LOCK_PERF_EN defined: adds outputs perf_stall_cycles (32 bits) and perf_alloc_count (32 bits).
  - perf_stall_cycles increments for each cycle with in_valid && ~in_ready due to a conflict or a full table; backpressure from out_ready is excluded.
  - perf_alloc_count increments on each allocation.
  - Both counters reset to 0 and wrap.
- Undefined: neither port nor counter exists; the remaining behaviour is identical.

## Structure
- VX_om_pkg:
  - om_lock_entry_t {valid, mask[NUM_LANES-1:0], pos_x/pos_y arrays};
  - localparam OM_LOCK_SIZE (the default LOCK_SIZE).
- Sub-module om_lock_match: combinational comparator of one request against all slots, with the release bypass mask as input. It outputs a per-slot conflict vector.
- The top module holds the slot table, free-slot priority encoder, counter, pipe register and the VX_OM_LOCK_PERF_EN logic.

## Test plan
- Read at lanes {(1,1),(2,1),(3,1),(4,1)} mask 1111, then a read containing (3,1):
  - first request: out_slot=0, lock_count=1;
  - second request: stalls; accepted the cycle rel_valid=1, rel_slot=0 is asserted.
- Eight non-overlapping reads with no releases: slots 0..7 are allocated and lock_full=1.
  - A ninth read stalls.
  - A blind write at a free pixel passes with out_slot=0.
- Release slot 3 and a new non-conflicting read in the same cycle: the read waits one cycle, then takes slot 3 (lowest free); lock_count stays 8.
- Read mask 0001 at (5,5), then a read mask 0010 at lane1=(5,5), lane0=(5,5) inactive: the second request stalls; a read with (5,5) only on an inactive lane passes.
- out_ready=0 for 3 cycles with out_valid=1: in_ready=0, and the output holds stable with its data unchanged.
  - Reset is asserted mid-stall: lock_count=0 and out_valid=0 immediately; the next read gets slot 0.
- With VX_OM_LOCK_PERF_EN: 5 conflict-stall cycles plus 2 out_ready stall cycles give perf_stall_cycles=5.
